// File: rtl/ref_block_loader_if.sv
// Pixel-stream and block-presentation signals between the reference fetch path and the block loader.
// The master modport is the pixel source / block consumer side, the slave modport is the loader.
interface ref_block_loader_if #(
   parameter int BLK_DIM = 15,
   parameter int PIX_W   = 8
);
   localparam int BLK_PIX = BLK_DIM * BLK_DIM;

   logic [PIX_W-1:0]         pix_in;
   logic                     pix_valid;
   logic                     pix_sof;
   logic                     pix_ready;
   logic [BLK_PIX*PIX_W-1:0] out_block;
   logic                     block_valid;
   logic                     block_ready;
   logic                     sof_err;
   logic [15:0]              blk_count;

   modport master (
      output pix_in, pix_valid, pix_sof, block_ready,
      input  pix_ready, out_block, block_valid, sof_err, blk_count
   );

   modport slave (
      input  pix_in, pix_valid, pix_sof, block_ready,
      output pix_ready, out_block, block_valid, sof_err, blk_count
   );
endinterface

// File: rtl/ref_block_loader.sv
// Double-buffered raster-to-block packer: fills one 15x15 bank while the other is presented
// to the interpolator, releasing presented blocks on a block-level valid/ready handshake.
module ref_block_loader #(
   parameter int BLK_DIM = 15,
   parameter int PIX_W   = 8
) (
   input  logic              clk,
   input  logic              reset,
   ref_block_loader_if.slave bus
);
   localparam int BLK_PIX = BLK_DIM * BLK_DIM;
   localparam int BLK_W   = BLK_PIX * PIX_W;
   localparam int PTR_W   = $clog2(BLK_PIX);
   localparam int OFF_W   = $clog2(BLK_W);
   localparam logic [PTR_W-1:0] LAST_IDX = PTR_W'(BLK_PIX - 1);

   logic [BLK_W-1:0] bank [2];
   logic [1:0]       full;
   logic [1:0]       full_nxt;
   logic             wsel;
   logic             rsel;
   logic             wsel_nxt;
   logic             rsel_nxt;
   logic [PTR_W-1:0] ptr;
   logic [PTR_W-1:0] ptr_nxt;
   logic [PTR_W-1:0] wr_idx;
   logic [OFF_W-1:0] wr_off;
   logic             pix_ready_q;
   logic             block_valid_q;
   logic             sof_err_q;
   logic [15:0]      blk_count_q;
   logic             accept;
   logic             restart;
   logic             complete;
   logic             release_blk;

   // The write bank is never full while accepting, so it can never be the presented bank.
   always_comb begin
      accept      = bus.pix_valid && pix_ready_q;
      release_blk = block_valid_q && bus.block_ready;
      restart     = accept && bus.pix_sof && (ptr != '0);
      wr_idx      = restart ? '0 : ptr;
      wr_off      = OFF_W'(wr_idx) * OFF_W'(PIX_W);
      complete    = accept && (wr_idx == LAST_IDX);

      ptr_nxt = ptr;
      if (accept) begin
         ptr_nxt = complete ? '0 : wr_idx + 1'b1;
      end

      full_nxt = full;
      if (complete) begin
         full_nxt[wsel] = 1'b1;
      end
      if (release_blk) begin
         full_nxt[rsel] = 1'b0;
      end

      wsel_nxt = wsel ^ complete;
      rsel_nxt = rsel ^ release_blk;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         bank[0]       <= '0;
         bank[1]       <= '0;
         full          <= '0;
         wsel          <= 1'b0;
         rsel          <= 1'b0;
         ptr           <= '0;
         pix_ready_q   <= 1'b0;
         block_valid_q <= 1'b0;
         sof_err_q     <= 1'b0;
         blk_count_q   <= '0;
      end else begin
         if (accept) begin
            bank[wsel][wr_off +: PIX_W] <= bus.pix_in;
         end
         full          <= full_nxt;
         wsel          <= wsel_nxt;
         rsel          <= rsel_nxt;
         ptr           <= ptr_nxt;
         // Flags look ahead at the post-edge bank pointers so completion/release show up next cycle.
         pix_ready_q   <= !full_nxt[wsel_nxt];
         block_valid_q <= full_nxt[rsel_nxt];
         if (restart) begin
            sof_err_q <= 1'b1;
         end
         if (release_blk) begin
            blk_count_q <= blk_count_q + 16'd1;
         end
      end
   end

   assign bus.pix_ready   = pix_ready_q;
   assign bus.block_valid = block_valid_q;
   assign bus.out_block   = bank[rsel];
   assign bus.sof_err     = sof_err_q;
   assign bus.blk_count   = blk_count_q;
endmodule
